// File: rtl/lampfpu_log_iter.sv
// Multi-cycle log2 unit for the lampFPU using bitwise repeated squaring.
// Ready/valid on both sides; operand class flags arrive precomputed.
module lampfpu_log_iter #(
  parameter int E_DW  = 8,
  parameter int F_DW  = 7,
  parameter int GUARD = 4,
  parameter int ITER  = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            s_op_i,
  input  logic [E_DW-1:0] e_op_i,
  input  logic [F_DW-1:0] f_op_i,
  input  logic            isZ_op_i,
  input  logic            isInf_op_i,
  input  logic            isSNAN_op_i,
  input  logic            isQNAN_op_i,
  output logic            s_res_o,
  output logic [E_DW-1:0] e_res_o,
  output logic [F_DW-1:0] f_res_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            isToRound_o,
  output logic            isInvalid_o
);

  localparam int M    = F_DW + 1 + GUARD;
  localparam int BIAS = 2**(E_DW-1) - 1;
  localparam int VW   = E_DW + 1 + ITER;
  localparam int CW   = $clog2(ITER + 1);
  localparam int QW   = $clog2(VW);

  typedef enum logic [1:0] {IDLE, SQR, NORM, DONE} state_t;

  state_t                  state, state_nxt;
  logic [M-1:0]            m_q;
  logic signed [E_DW:0]    int_q;
  logic [ITER-1:0]         bits_q;
  logic [CW-1:0]           cnt_q;
  logic [2*M-1:0]          p;

  logic                    is_nan, is_ninf, is_neg, is_pinf, is_special;
  logic [VW-1:0]           v, a, a_norm;
  logic [QW-1:0]           q;
  logic [E_DW-1:0]         e_norm;
  logic [F_DW-1:0]         f_norm;
  logic                    rnd_norm;

  assign p = {{M{1'b0}}, m_q} * {{M{1'b0}}, m_q};

  // Special-operand decode, in priority order
  always_comb begin
    is_nan     = isSNAN_op_i | isQNAN_op_i;
    is_ninf    = isZ_op_i | (e_op_i == '0);
    is_neg     = s_op_i;
    is_pinf    = isInf_op_i;
    is_special = is_nan | is_ninf | is_neg | is_pinf;
  end

  // Normalisation of the signed fixed-point value {I, bits}
  always_comb begin
    v = {int_q, bits_q};
    a = v[VW-1] ? (~v + VW'(1)) : v;
    q = '0;
    for (int unsigned i = 0; i < VW; i++) begin
      if (a[i]) q = QW'(i);
    end
    a_norm   = a << (QW'(VW - 1) - q);
    f_norm   = a_norm[VW-2 -: F_DW];
    rnd_norm = |a_norm[VW-2-F_DW:0];
    e_norm   = E_DW'(int'(q) + BIAS - ITER);
  end

  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    valid_o   = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_nxt = is_special ? DONE : SQR;
      end
      SQR:  if (cnt_q == CW'(ITER - 1)) state_nxt = NORM;
      NORM: state_nxt = DONE;
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      m_q         <= '0;
      int_q       <= '0;
      bits_q      <= '0;
      cnt_q       <= '0;
      s_res_o     <= 1'b0;
      e_res_o     <= '0;
      f_res_o     <= '0;
      isToRound_o <= 1'b0;
      isInvalid_o <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (valid_i) begin
          m_q    <= {1'b1, f_op_i, {GUARD{1'b0}}};
          int_q  <= $signed({1'b0, e_op_i}) - $signed((E_DW+1)'(BIAS));
          bits_q <= '0;
          cnt_q  <= '0;
          if (is_special) begin
            isToRound_o <= 1'b0;
            e_res_o     <= '1;
            if (is_nan || (!is_ninf && is_neg)) begin
              s_res_o     <= 1'b0;
              f_res_o     <= {1'b1, {(F_DW-1){1'b0}}};
              isInvalid_o <= 1'b1;
            end else begin
              s_res_o     <= is_ninf;
              f_res_o     <= '0;
              isInvalid_o <= 1'b0;
            end
          end
        end
        SQR: begin
          cnt_q <= cnt_q + CW'(1);
          if (p[2*M-1]) begin
            m_q    <= p[2*M-1:M];
            bits_q <= {bits_q[ITER-2:0], 1'b1};
          end else begin
            m_q    <= p[2*M-2:M-1];
            bits_q <= {bits_q[ITER-2:0], 1'b0};
          end
        end
        NORM: begin
          isInvalid_o <= 1'b0;
          s_res_o     <= v[VW-1];
          if (a == '0) begin
            e_res_o     <= '0;
            f_res_o     <= '0;
            isToRound_o <= 1'b0;
          end else begin
            e_res_o     <= e_norm;
            f_res_o     <= f_norm;
            isToRound_o <= rnd_norm;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
